// File: rtl/pipe_addsub.sv
// Pipelined add/subtract with optional saturation: one CHUNK-bit carry-lookahead
// slice per stage, ripple carry between stages through registers.
module pipe_addsub #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             ovfl,
  output logic             zero,
  output logic             neg
);

  localparam int STAGES = WIDTH / CHUNK;
  localparam int LAST   = STAGES - 1;

  logic adv;

  // Registers at index k feed stage k; stage 0 is fed straight from the ports.
  logic [WIDTH-1:0] a_q  [STAGES];
  logic [WIDTH-1:0] b_q  [STAGES];
  logic [WIDTH-1:0] s_q  [STAGES];
  logic [1:0]       op_q [STAGES];
  logic             v_q  [STAGES];
  logic             c_q  [STAGES];

  logic [WIDTH-1:0] st_a  [STAGES];
  logic [WIDTH-1:0] st_b  [STAGES];
  logic [WIDTH-1:0] st_s  [STAGES];
  logic [1:0]       st_op [STAGES];
  logic             st_v  [STAGES];
  logic             st_c  [STAGES];

  logic [WIDTH-1:0] nx_s  [STAGES];
  logic             nx_c  [STAGES];
  logic             c_msb [STAGES];

  logic             g, p, grp_g, grp_p, cin_i;
  logic             raw_ovf;
  logic             sat;
  logic [WIDTH-1:0] fin_sum;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // Subtraction is a + ~b + 1; the +1 enters as the stage-0 carry.
  always_comb begin : stage_in
    st_a[0]  = a;
    st_b[0]  = op[0] ? ~b : b;
    st_s[0]  = '0;
    st_op[0] = op;
    st_v[0]  = in_valid;
    st_c[0]  = op[0];
    for (int k = 1; k < STAGES; k++) begin
      st_a[k]  = a_q[k];
      st_b[k]  = b_q[k];
      st_s[k]  = s_q[k];
      st_op[k] = op_q[k];
      st_v[k]  = v_q[k];
      st_c[k]  = c_q[k];
    end
  end

  always_comb begin : cla
    g     = 1'b0;
    p     = 1'b0;
    grp_g = 1'b0;
    grp_p = 1'b1;
    cin_i = 1'b0;
    for (int k = 0; k < STAGES; k++) begin
      nx_s[k] = st_s[k];
      grp_g   = 1'b0;
      grp_p   = 1'b1;
      for (int i = 0; i < CHUNK; i++) begin
        g     = st_a[k][k*CHUNK+i] & st_b[k][k*CHUNK+i];
        p     = st_a[k][k*CHUNK+i] ^ st_b[k][k*CHUNK+i];
        cin_i = grp_g | (grp_p & st_c[k]);
        nx_s[k][k*CHUNK+i] = p ^ cin_i;
        grp_g = g | (p & grp_g);
        grp_p = p & grp_p;
      end
      // cin_i now holds the carry into this slice's top bit.
      c_msb[k] = cin_i;
      nx_c[k]  = grp_g | (grp_p & st_c[k]);
    end
  end

  always_comb begin : saturate
    raw_ovf = c_msb[LAST] ^ nx_c[LAST];
    sat     = st_op[LAST][1] & raw_ovf;
    fin_sum = nx_s[LAST];
    if (sat) begin
      fin_sum = st_a[LAST][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                    : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        a_q[k]  <= '0;
        b_q[k]  <= '0;
        s_q[k]  <= '0;
        op_q[k] <= '0;
        v_q[k]  <= 1'b0;
        c_q[k]  <= 1'b0;
      end
      out_valid <= 1'b0;
      sum       <= '0;
      ovfl      <= 1'b0;
      zero      <= 1'b0;
      neg       <= 1'b0;
    end else if (adv) begin
      for (int k = 0; k < LAST; k++) begin
        a_q[k+1]  <= st_a[k];
        b_q[k+1]  <= st_b[k];
        s_q[k+1]  <= nx_s[k];
        op_q[k+1] <= st_op[k];
        v_q[k+1]  <= st_v[k];
        c_q[k+1]  <= nx_c[k];
      end
      out_valid <= st_v[LAST];
      sum       <= fin_sum;
      ovfl      <= raw_ovf;
      zero      <= (fin_sum == '0);
      neg       <= fin_sum[WIDTH-1];
    end
  end

endmodule

// File: tb/tb_pipe_addsub.sv
// Self-checking bench for pipe_addsub (WIDTH=16, CHUNK=4): directed corner cases
// plus random traffic against an integer-arithmetic reference and result queue.
module tb_pipe_addsub;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, out_valid, out_ready;
  logic        ovfl, zero, neg;
  logic [15:0] a, b, sum;
  logic [1:0]  op;

  int checks = 0;
  int errors = 0;
  int popped = 0;
  int accepted = 0;

  logic [18:0] q[$];
  logic        s_in_ready, s_out_valid, s_ovfl, s_zero, s_neg;
  logic [15:0] s_sum;
  logic        hist [32];
  logic        ovh  [32];

  pipe_addsub #(.WIDTH(16), .CHUNK(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .ovfl(ovfl), .zero(zero), .neg(neg)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  // Result packed as {neg, zero, ovfl, sum}, from true signed arithmetic.
  function automatic logic [18:0] ref_res(input logic [15:0] x, input logic [15:0] y,
                                          input logic [1:0] o);
    int sx, sy, r;
    logic [15:0] s;
    logic v;
    sx = $signed(x);
    sy = $signed(y);
    r  = o[0] ? sx - sy : sx + sy;
    v  = (r > 32767) || (r < -32768);
    s  = r[15:0];
    if (o[1] && v) s = (r > 0) ? 16'h7FFF : 16'h8000;
    return {s[15], (s == 16'h0000), v, s};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    s_in_ready  = in_ready;
    s_out_valid = out_valid;
    s_sum       = sum;
    s_ovfl      = ovfl;
    s_zero      = zero;
    s_neg       = neg;
    chk("in_ready", {31'b0, s_in_ready}, {31'b0, !(s_out_valid && !out_ready)});
    if (s_out_valid) begin
      if (q.size() == 0) chk("spurious_out", {31'b0, s_out_valid}, 32'd0);
      else begin
        chk(out_ready ? "result" : "stall_hold",
            {13'b0, s_neg, s_zero, s_ovfl, s_sum}, {13'b0, q[0]});
        if (out_ready) begin
          void'(q.pop_front());
          popped++;
        end
      end
    end
    if (in_valid && s_in_ready) begin
      q.push_back(ref_res(a, b, op));
      accepted++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic directed(input string tag, input logic [15:0] x, input logic [15:0] y,
                          input logic [1:0] o, input logic [18:0] exp);
    int lat;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    a = x; b = y; op = o;
    tick();
    in_valid = 1'b0;
    a = 16'($urandom); b = 16'($urandom); op = 2'($urandom);
    for (lat = 1; lat <= 12; lat++) begin
      tick();
      if (s_out_valid) break;
    end
    chk({tag, "_latency"}, lat, 4);
    chk(tag, {13'b0, s_neg, s_zero, s_ovfl, s_sum}, {13'b0, exp});
  endtask

  initial begin
    int p0, a0;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; op = '0;

    #3;
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_sum", {16'b0, sum}, 32'd0);
    chk("rst_flags", {29'b0, ovfl, zero, neg}, 32'd0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    directed("add_ovf",   16'h7FFF, 16'h0001, 2'b00, {1'b1, 1'b0, 1'b1, 16'h8000});
    directed("adds_sat",  16'h7FFF, 16'h0001, 2'b10, {1'b0, 1'b0, 1'b1, 16'h7FFF});
    directed("subs_sat",  16'h8000, 16'h0001, 2'b11, {1'b1, 1'b0, 1'b1, 16'h8000});
    directed("sub_wrap",  16'h8000, 16'h0001, 2'b01, {1'b0, 1'b0, 1'b1, 16'h7FFF});
    directed("sub_zero",  16'h1234, 16'h1234, 2'b01, {1'b0, 1'b1, 1'b0, 16'h0000});
    directed("add_carry", 16'hFFFF, 16'h0001, 2'b00, {1'b0, 1'b1, 1'b0, 16'h0000});
    directed("subs_pos",  16'h7FFF, 16'h8000, 2'b11, {1'b0, 1'b0, 1'b1, 16'h7FFF});
    directed("adds_neg",  16'h8000, 16'h8000, 2'b10, {1'b1, 1'b0, 1'b1, 16'h8000});
    directed("adds_nosat",16'h1000, 16'hF000, 2'b10, {1'b0, 1'b1, 1'b0, 16'h0000});

    // Bubbles at full throughput: out_valid is in_valid delayed by 4 cycles.
    out_ready = 1'b1;
    for (int c = 0; c < 32; c++) begin
      if (c >= 28)      in_valid = 1'b0;
      else if (c < 14)  in_valid = (c % 2 == 0);
      else              in_valid = 1'($urandom_range(0, 1));
      a = 16'($urandom); b = 16'($urandom); op = 2'($urandom);
      hist[c] = in_valid;
      tick();
      ovh[c] = s_out_valid;
    end
    for (int c = 0; c < 32; c++)
      chk("bubble_pattern", {31'b0, ovh[c]}, {31'b0, (c >= 4) ? hist[(c >= 4) ? c - 4 : 0] : 1'b0});

    // Eight back-to-back beats with a three-cycle downstream stall.
    p0 = popped; a0 = accepted;
    for (int c = 0; c < 40; c++) begin
      in_valid  = (accepted - a0) < 8;
      out_ready = !(c >= 6 && c < 9);
      a = 16'($urandom); b = 16'($urandom); op = 2'($urandom);
      tick();
      if (q.size() == 0 && (accepted - a0) == 8) break;
    end
    chk("stall_delivered", popped - p0, 8);

    // Reset with beats in flight and one result parked at the output.
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      in_valid = 1'b1;
      a = 16'($urandom); b = 16'($urandom); op = 2'($urandom);
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b0;
    tick();
    chk("pre_reset_valid", {31'b0, out_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("midrst_sum", {16'b0, sum}, 32'd0);
    chk("midrst_in_ready", {31'b0, in_ready}, 32'd1);
    q.delete();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      tick();
      chk("no_stale", {31'b0, s_out_valid}, 32'd0);
    end
    directed("post_reset", 16'h0003, 16'h0004, 2'b00, {1'b0, 1'b0, 1'b0, 16'h0007});

    // Random traffic with random backpressure.
    for (int c = 0; c < 300; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      a = 16'($urandom); b = 16'($urandom); op = 2'($urandom);
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 20 && q.size() != 0; c++) tick();
    chk("drain_empty", q.size(), 0);
    repeat (4) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_addsub.md
PIPE_ADDSUB -- requirements
Module: pipe_addsub

Interface
REQ-001 SHALL have parameter WIDTH, default 16: operand/result width in bits; must be an integer multiple of CHUNK.
REQ-002 SHALL have parameter CHUNK, default 4: bits added per pipeline stage; STAGES = WIDTH/CHUNK is derived, not overridable.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port in_valid  input  1  operand beat present.
REQ-006 SHALL have port in_ready  output  1  block accepts beat this cycle.
REQ-007 SHALL have port a  input  WIDTH  operand A, two's complement.
REQ-008 SHALL have port b  input  WIDTH  operand B, two's complement.
REQ-009 SHALL have port op  input  2  operation: 00 ADD, 01 SUB, 10 ADDS (saturating), 11 SUBS (saturating).
REQ-010 SHALL have port out_valid  output  1  result beat present.
REQ-011 SHALL have port out_ready  input  1  downstream accepts result.
REQ-012 SHALL have port sum  output  WIDTH  result.
REQ-013 SHALL have port ovfl  output  1  signed overflow of unsaturated result.
REQ-014 SHALL have port zero  output  1  sum == 0.
REQ-015 SHALL have port neg  output  1  sum[WIDTH-1].

Function
REQ-016 SHALL implement SUB/SUBS as a + ~b with stage-0 carry-in 1; ADD/ADDS use carry-in 0.
REQ-017 SHALL, in stage k (0..STAGES-1), add bits [k*CHUNK +: CHUNK] with a CHUNK-bit carry-lookahead (per-bit g=a&b, p=a^b, group generate/propagate), taking carry-in from stage k-1's registered carry-out.
REQ-018 SHALL carry unprocessed upper operand slices, op, and completed lower sum slices forward in pipeline registers, so each slice is added exactly once.
REQ-019 SHALL compute raw overflow as carry into MSB XOR carry out of MSB, captured in the final stage.
REQ-020 SHALL, for ADDS/SUBS with raw overflow, replace sum with 0 followed by WIDTH-1 ones (max positive) when a[WIDTH-1]==0, else 1 followed by WIDTH-1 zeros (min negative); no overflow leaves sum unchanged.
REQ-021 SHALL report ovfl as raw overflow in all modes, including when saturation applied.
REQ-022 SHALL derive zero and neg from the final (post-saturation) sum.
REQ-023 SHALL use one global advance signal adv = !out_valid || out_ready; in_ready = adv; all stages shift only when adv=1.
REQ-024 SHALL accept a beat on the edge where in_valid && in_ready; an accepted beat appears at the output exactly STAGES advancing edges later.
REQ-025 SHALL track a valid bit per stage; bubbles (in_valid=0 while adv=1) propagate as invalid stages and never raise out_valid.
REQ-026 SHALL sustain one result per cycle when in_valid and out_ready are held high.
REQ-027 SHALL hold sum, ovfl, zero, neg, out_valid stable while out_valid && !out_ready.
REQ-028 SHALL deliver results in acceptance order with no loss or duplication under any out_ready pattern.
REQ-029 SHALL, when CHUNK == WIDTH, behave as a single-stage registered adder (latency 1).
REQ-030 SHALL ignore a, b, op when in_valid=0 or in_ready=0.

Reset
REQ-031 SHALL, on rst_n low, asynchronously clear all stage valid bits, out_valid=0, sum=0, ovfl=0, zero=0, neg=0.
REQ-032 SHALL discard all in-flight beats on reset mid-operation; no stale result appears after release.
REQ-033 SHALL present in_ready=1 while in reset and on the first edge after rst_n rises.

Verification (WIDTH=16, CHUNK=4)
REQ-034 SHALL cover ADD 0x7FFF+0x0001 -> sum 0x8000, ovfl 1, neg 1, zero 0, out_valid 4 edges after acceptance.
REQ-035 SHALL cover ADDS 0x7FFF+0x0001 -> sum 0x7FFF, ovfl 1, neg 0; SUBS 0x8000-0x0001 -> sum 0x8000, ovfl 1; SUB same operands -> 0x7FFF, ovfl 1.
REQ-036 SHALL cover SUB 0x1234-0x1234 -> sum 0x0000, zero 1, ovfl 0, neg 0; ADD 0xFFFF+0x0001 -> 0x0000, ovfl 0.
REQ-037 SHALL cover 8 back-to-back beats with out_ready low for 3 cycles mid-stream -> in_ready low exactly while out_valid && !out_ready, all 8 results in order, outputs stable during stall.
REQ-038 SHALL cover rst_n pulsed low with 3 beats in flight -> out_valid 0 immediately, no output after release until a new beat is accepted.
REQ-039 SHALL cover alternating in_valid (bubbles) at full out_ready -> out_valid pattern equals input pattern delayed 4 cycles.
